vga_display_ctrl: RTL and testbench

//  Display-side end of the sprite pixel interface: generates 640x480@60 timing (DrawX, DrawY, blank,
//  hs, vs) that all sprite renderers consume, and composites their registered RGB444 + alpha-flag

---
 rtl/vga_display_ctrl_pkg.sv | 45 ++++
 rtl/vga_display_ctrl_if.sv | 34 +++
 rtl/vga_display_ctrl_axis_fsm.sv | 47 ++++
 rtl/vga_display_ctrl.sv | 97 +++++++++
 tb/tb_vga_display_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_display_ctrl_pkg.sv
// Shared types, default 640x480@60 timing and test-bar colours for the VGA display controller.
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_e;

    localparam int CNT_W        = 10;
    localparam int PIPE_DLY     = 2;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int BAR_PX       = 80;

    function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] x);
        logic [CNT_W-1:0] q;
        q = x / CNT_W'(BAR_PX);
        return q[2:0];
    endfunction

    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        rgb444_t c;
        case (idx)
            3'd0:    c = rgb444_t'(12'h000);
            3'd1:    c = rgb444_t'(12'hF00);
            3'd2:    c = rgb444_t'(12'h0F0);
            3'd3:    c = rgb444_t'(12'h00F);
            3'd4:    c = rgb444_t'(12'hFF0);
            3'd5:    c = rgb444_t'(12'h0FF);
            3'd6:    c = rgb444_t'(12'hF0F);
            default: c = rgb444_t'(12'hFFF);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_display_ctrl_if.sv
// Sprite pixel interface between renderers and the display controller.
// VGA_TEST_PATTERN_EN adds the test_mode select.
interface vga_display_ctrl_if #(parameter int NUM_LAYERS = 4);
    import vga_pkg::*;

    rgb444_t [NUM_LAYERS-1:0] layer_rgb;
    logic    [NUM_LAYERS-1:0] layer_a;
    rgb444_t                  bg_rgb;
`ifdef VGA_TEST_PATTERN_EN
    logic                     test_mode;
`endif
    logic [CNT_W-1:0]         DrawX;
    logic [CNT_W-1:0]         DrawY;
    logic                     blank;
    logic                     hs;
    logic                     vs;
    logic [3:0]               vga_r;
    logic [3:0]               vga_g;
    logic [3:0]               vga_b;
    logic                     frame_start;

`ifdef VGA_TEST_PATTERN_EN
    modport master (input  layer_rgb, layer_a, bg_rgb, test_mode,
                    output DrawX, DrawY, blank, hs, vs, vga_r, vga_g, vga_b, frame_start);
    modport slave  (output layer_rgb, layer_a, bg_rgb, test_mode,
                    input  DrawX, DrawY, blank, hs, vs, vga_r, vga_g, vga_b, frame_start);
`else
    modport master (input  layer_rgb, layer_a, bg_rgb,
                    output DrawX, DrawY, blank, hs, vs, vga_r, vga_g, vga_b, frame_start);
    modport slave  (output layer_rgb, layer_a, bg_rgb,
                    input  DrawX, DrawY, blank, hs, vs, vga_r, vga_g, vga_b, frame_start);
`endif

endinterface

// File: rtl/vga_display_ctrl_axis_fsm.sv
// One timing axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK phase, advanced when en_i is high.
module vga_axis_fsm import vga_pkg::*; #(
    parameter int ACTIVE_LEN = H_ACTIVE_DEF,
    parameter int FP_LEN     = H_FP_DEF,
    parameter int SYNC_LEN   = H_SYNC_DEF,
    parameter int BP_LEN     = H_BP_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output axis_state_e      state_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE_LEN);
    localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE_LEN + FP_LEN);
    localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    axis_state_e      state_q;

    assign wrap_o = en_i && (cnt_q == LAST);
    assign cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    // Phase follows the value the counter is about to take, so state and count stay aligned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            state_q <= ACTIVE;
        end else if (en_i) begin
            cnt_q <= cnt_d;
            case (state_q)
                ACTIVE:  if (cnt_d == FRONT_AT) state_q <= FRONT;
                FRONT:   if (cnt_d == SYNC_AT)  state_q <= SYNC;
                SYNC:    if (cnt_d == BACK_AT)  state_q <= BACK;
                BACK:    if (cnt_d == '0)       state_q <= ACTIVE;
                default: state_q <= ACTIVE;
            endcase
        end
    end

    assign cnt_o   = cnt_q;
    assign state_o = state_q;

endmodule

// File: rtl/vga_display_ctrl.sv
// 640x480 VGA timing generator and fixed-priority sprite compositor with sync/pixel alignment.
// VGA_TEST_PATTERN_EN enables the eight-bar test pattern selected by test_mode.
module vga_display_ctrl import vga_pkg::*; #(
    parameter int NUM_LAYERS = 4,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    vga_display_ctrl_if.master bus
);

    logic             run_q;
    logic             fs_q;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    axis_state_e      h_state, v_state;
    logic             h_wrap, v_wrap;
    logic             blank;
    logic [PIPE_DLY-1:0] vis_q, hs_q, vs_q;
    rgb444_t          pix_q, pix_d;

    function automatic rgb444_t composite(input rgb444_t [NUM_LAYERS-1:0] rgb,
                                          input logic    [NUM_LAYERS-1:0] a,
                                          input rgb444_t                  bg);
        rgb444_t px;
        px = bg;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (a[i]) px = rgb[i];
        end
        return px;
    endfunction

    vga_axis_fsm #(.ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP)) u_h_axis (
        .clk_i(vga_clk), .rst_ni(reset_n), .en_i(run_q),
        .cnt_o(h_cnt), .state_o(h_state), .wrap_o(h_wrap)
    );

    vga_axis_fsm #(.ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP)) u_v_axis (
        .clk_i(vga_clk), .rst_ni(reset_n), .en_i(h_wrap),
        .cnt_o(v_cnt), .state_o(v_state), .wrap_o(v_wrap)
    );

    assign blank = run_q && (h_state == ACTIVE) && (v_state == ACTIVE);

    // run_q holds the counters for one cycle after reset so (0,0) is presented with frame_start.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            fs_q  <= 1'b0;
            vis_q <= '0;
            hs_q  <= '1;
            vs_q  <= '1;
            pix_q <= '0;
        end else begin
            run_q <= 1'b1;
            fs_q  <= !run_q || v_wrap;
            vis_q <= {vis_q[PIPE_DLY-2:0], blank};
            hs_q  <= {hs_q[PIPE_DLY-2:0], h_state != SYNC};
            vs_q  <= {vs_q[PIPE_DLY-2:0], v_state != SYNC};
            pix_q <= pix_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [CNT_W-1:0] x_q;

    // Matches the one-cycle renderer latency so bars line up with layer pixels.
    always_ff @(posedge vga_clk) begin
        x_q <= h_cnt;
    end
`endif

    always_comb begin
        pix_d = composite(bus.layer_rgb, bus.layer_a, bus.bg_rgb);
`ifdef VGA_TEST_PATTERN_EN
        if (bus.test_mode) pix_d = bar_colour(bar_index(x_q));
`endif
        if (!vis_q[PIPE_DLY-2]) pix_d = '0;
    end

    assign bus.DrawX       = h_cnt;
    assign bus.DrawY       = v_cnt;
    assign bus.blank       = blank;
    assign bus.frame_start = fs_q;
    assign bus.hs          = hs_q[PIPE_DLY-1];
    assign bus.vs          = vs_q[PIPE_DLY-1];
    assign bus.vga_r       = pix_q.r;
    assign bus.vga_g       = pix_q.g;
    assign bus.vga_b       = pix_q.b;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Scoreboard bench for vga_display_ctrl: full horizontal timing, shortened vertical frame.
`timescale 1ns/1ps
module tb_vga_display_ctrl;
    import vga_pkg::*;

    localparam int HA = 640, HFP = 16, HS = 96, HBP = 48, HT = 800;
    localparam int VA = 16,  VFP = 2,  VS = 2,  VBP = 3,  VT = 23;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    vga_display_ctrl_if #(.NUM_LAYERS(4)) bus ();

    vga_display_ctrl #(
        .NUM_LAYERS(4),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .vga_clk(clk),
        .reset_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit sb_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          kind;   // 0 rgb, 1 hs, 2 vs
        logic [11:0] val;
        string       name;
    } exp_t;

    typedef struct {
        int          x;
        int          y;
        logic [3:0]  a;
        logic [11:0] l0, l1, l2, l3, bg;
        bit          tm;
        logic [11:0] exp;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic add_vec(input int x, input int y, input logic [3:0] a,
                           input logic [11:0] l0, input logic [11:0] l1,
                           input logic [11:0] l2, input logic [11:0] l3,
                           input logic [11:0] bg, input bit tm,
                           input logic [11:0] exp, input string name);
        vec_t v;
        v.x = x; v.y = y; v.a = a; v.l0 = l0; v.l1 = l1; v.l2 = l2; v.l3 = l3;
        v.bg = bg; v.tm = tm; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input int due, input int kind, input logic [11:0] val, input string name);
        exp_t e;
        e.due = due; e.kind = kind; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_xy(input int x, input int y, input int budget, input string name);
        int n = 0;
        while (!(bus.DrawX == 10'(x) && bus.DrawY == 10'(y)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: position (%0d,%0d) not reached within %0d cycles", name, x, y, budget);
        end
    endtask

    // Renderer model: pixel sampled in cycle t is presented during t+1, visible on the pins at t+2.
    initial begin : driver
        int px, py, pc;
        bus.layer_a   = '0;
        bus.layer_rgb = '0;
        bus.bg_rgb    = '0;
`ifdef VGA_TEST_PATTERN_EN
        bus.test_mode = 1'b0;
`endif
        forever begin
            @(negedge clk);
            px = int'(bus.DrawX);
            py = int'(bus.DrawY);
            pc = cyc;
            @(posedge clk);
            #1;
            bus.layer_a   = '0;
            bus.layer_rgb = '0;
            bus.bg_rgb    = '0;
`ifdef VGA_TEST_PATTERN_EN
            bus.test_mode = 1'b0;
`endif
            if (sb_en && rst_n) begin
                foreach (vecs[i]) begin
                    if (vecs[i].x == px && vecs[i].y == py) begin
                        bus.layer_a      = vecs[i].a;
                        bus.layer_rgb[0] = vecs[i].l0;
                        bus.layer_rgb[1] = vecs[i].l1;
                        bus.layer_rgb[2] = vecs[i].l2;
                        bus.layer_rgb[3] = vecs[i].l3;
                        bus.bg_rgb       = vecs[i].bg;
`ifdef VGA_TEST_PATTERN_EN
                        bus.test_mode    = vecs[i].tm;
`endif
                        push_exp(pc + 2, 0, vecs[i].exp, vecs[i].name);
                    end
                end
                if (py == 2 && px == HA + HFP) begin
                    push_exp(pc + 1,      1, 12'h1, "hs_before_pulse");
                    push_exp(pc + 2,      1, 12'h0, "hs_pulse_first");
                    push_exp(pc + 1 + HS, 1, 12'h0, "hs_pulse_last");
                    push_exp(pc + 2 + HS, 1, 12'h1, "hs_after_pulse");
                end
                if (px == 0 && py == VA + VFP) begin
                    push_exp(pc + 1, 2, 12'h1, "vs_before_pulse");
                    push_exp(pc + 2, 2, 12'h0, "vs_pulse_first");
                end
                if (px == 0 && py == VA + VFP + VS) begin
                    push_exp(pc + 1, 2, 12'h0, "vs_pulse_last");
                    push_exp(pc + 2, 2, 12'h1, "vs_after_pulse");
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    case (sb[i].kind)
                        0:       chk(sb[i].name, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(sb[i].val));
                        1:       chk(sb[i].name, 32'(bus.hs), 32'(sb[i].val[0]));
                        default: chk(sb[i].name, 32'(bus.vs), 32'(sb[i].val[0]));
                    endcase
                    sb.delete(i);
                end else if (sb[i].due < cyc) begin
                    chk({sb[i].name, "_missed"}, 32'(cyc), 32'(sb[i].due));
                    sb.delete(i);
                end
            end
        end
    end

    initial begin : watchdog
        #(60000 * 40);
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int fs_cnt, blank_cnt, hs_low, vs_low, seq_err, max_x, max_y, px, py, ex, ey;

        add_vec(200,  3, 4'b0110, 12'h00F, 12'hF00, 12'h0F0, 12'hFFF, 12'h777, 1'b0, 12'hF00, "prio_l1_over_l2");
        add_vec(100,  3, 4'b0000, 12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD, 12'h123, 1'b0, 12'h123, "bg_visible");
        add_vec(700,  3, 4'b0000, 12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD, 12'h123, 1'b0, 12'h000, "bg_hblank");
        add_vec(300,  3, 4'b1111, 12'hABC, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0, 12'hABC, "all_opaque_l0");
        add_vec(301,  3, 4'b1000, 12'h111, 12'h222, 12'h333, 12'h0A5, 12'h444, 1'b0, 12'h0A5, "only_l3");
        add_vec(639, 15, 4'b0100, 12'h111, 12'h222, 12'h5A5, 12'h333, 12'hFFF, 1'b0, 12'h5A5, "last_visible");
        add_vec(640, 15, 4'b0100, 12'h111, 12'h222, 12'h5A5, 12'h333, 12'hFFF, 1'b0, 12'h000, "first_hblank");
        add_vec( 10, 16, 4'b1111, 12'h111, 12'h222, 12'h333, 12'h444, 12'hFFF, 1'b0, 12'h000, "vblank_line");
        add_vec(  0,  1, 4'b0000, 12'h111, 12'h222, 12'h333, 12'h444, 12'h321, 1'b0, 12'h321, "line_start_bg");
        add_vec(799,  1, 4'b0000, 12'h111, 12'h222, 12'h333, 12'h444, 12'hFFF, 1'b0, 12'h000, "line_end_blank");
        add_vec( 85, 11, 4'b0001, 12'hABC, 12'h222, 12'h333, 12'h444, 12'h000, 1'b0, 12'hABC, "normal_path");
        add_vec(298, 12, 4'b0000, 12'h111, 12'h222, 12'h333, 12'h444, 12'hFFF, 1'b0, 12'hFFF, "pre_reset_pixel");
`ifdef VGA_TEST_PATTERN_EN
        add_vec(  0, 10, 4'b1111, 12'hABC, 12'h222, 12'h333, 12'h444, 12'h555, 1'b1, 12'h000, "bar0");
        add_vec( 85, 10, 4'b1111, 12'hABC, 12'h222, 12'h333, 12'h444, 12'h555, 1'b1, 12'hF00, "bar1");
        add_vec(400, 10, 4'b1111, 12'hABC, 12'h222, 12'h333, 12'h444, 12'h555, 1'b1, 12'h0FF, "bar5");
        add_vec(639, 10, 4'b1111, 12'hABC, 12'h222, 12'h333, 12'h444, 12'h555, 1'b1, 12'hFFF, "bar7");
        add_vec(640, 10, 4'b1111, 12'hABC, 12'h222, 12'h333, 12'h444, 12'h555, 1'b1, 12'h000, "bar_blank");
`endif

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_drawx", 32'(bus.DrawX), 0);
        chk("rst_drawy", 32'(bus.DrawY), 0);
        chk("rst_blank", 32'(bus.blank), 0);
        chk("rst_hs", 32'(bus.hs), 1);
        chk("rst_vs", 32'(bus.vs), 1);
        chk("rst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
        chk("rst_frame_start", 32'(bus.frame_start), 0);

        rst_n = 1'b1;
        sb_en = 1'b1;
        @(negedge clk);
        chk("first_drawx", 32'(bus.DrawX), 0);
        chk("first_drawy", 32'(bus.DrawY), 0);
        chk("first_blank", 32'(bus.blank), 1);
        chk("first_frame_start", 32'(bus.frame_start), 1);

        fs_cnt = 0; blank_cnt = 0; hs_low = 0; vs_low = 0; seq_err = 0;
        max_x = 0; max_y = 0; px = 0; py = 0;
        for (int i = 0; i < HT * VT; i++) begin
            if (i > 0) begin
                ex = (px == HT - 1) ? 0 : px + 1;
                ey = (px == HT - 1) ? ((py == VT - 1) ? 0 : py + 1) : py;
                if (int'(bus.DrawX) != ex || int'(bus.DrawY) != ey) seq_err++;
            end
            px = int'(bus.DrawX);
            py = int'(bus.DrawY);
            if (px > max_x) max_x = px;
            if (py > max_y) max_y = py;
            if (bus.frame_start) fs_cnt++;
            if (bus.blank) blank_cnt++;
            if (!bus.hs) hs_low++;
            if (!bus.vs) vs_low++;
            @(negedge clk);
        end
        chk("counter_sequence_errors", 32'(seq_err), 0);
        chk("drawx_max", 32'(max_x), HT - 1);
        chk("drawy_max", 32'(max_y), VT - 1);
        chk("frame_start_per_frame", 32'(fs_cnt), 1);
        chk("visible_cycles", 32'(blank_cnt), HA * VA);
        chk("hs_low_cycles", 32'(hs_low), HS * VT);
        chk("vs_low_cycles", 32'(vs_low), VS * HT);
        chk("frame2_drawx", 32'(bus.DrawX), 0);
        chk("frame2_drawy", 32'(bus.DrawY), 0);
        chk("frame2_frame_start", 32'(bus.frame_start), 1);

        wait_xy(300, 12, HT * VT + 10, "reach_reset_point");
        #2;
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_drawx", 32'(bus.DrawX), 0);
        chk("midrst_drawy", 32'(bus.DrawY), 0);
        chk("midrst_blank", 32'(bus.blank), 0);
        chk("midrst_hs", 32'(bus.hs), 1);
        chk("midrst_vs", 32'(bus.vs), 1);
        chk("midrst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
        chk("midrst_frame_start", 32'(bus.frame_start), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        chk("midrst_hold_drawx", 32'(bus.DrawX), 0);

        rst_n = 1'b1;
        sb_en = 1'b1;
        @(negedge clk);
        chk("restart_drawx", 32'(bus.DrawX), 0);
        chk("restart_drawy", 32'(bus.DrawY), 0);
        chk("restart_frame_start", 32'(bus.frame_start), 1);
        chk("restart_blank", 32'(bus.blank), 1);
        @(negedge clk);
        chk("restart_next_drawx", 32'(bus.DrawX), 1);
        chk("restart_next_frame_start", 32'(bus.frame_start), 0);

        wait_xy(0, 5, HT * 6, "reach_line5_after_restart");
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
